// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and fault helper for the load/store memory port
package lsu_pkg;
    localparam int MEM_AW = 14;
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
    function automatic logic bad_access(logic [1:0] size, logic [1:0] a);
        return (size == 2'd3) || (size == SZ_H && a[0]) || (size == SZ_W && a != 2'd0);
    endfunction
endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: core request/response channel and RAM port of the load/store unit
interface lsu_mem_port_if;
    logic req_valid;
    logic req_ready;
    logic req_we;
    logic [1:0] req_size;
    logic req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic rsp_valid;
    logic rsp_ready;
    logic [31:0] rsp_rdata;
    logic rsp_fault;
    logic mem_en;
    logic mem_ren;
    logic [7:0] mem_we;
    logic [lsu_pkg::MEM_AW-1:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    modport master(
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_rdata,
        input req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_en, mem_ren, mem_we, mem_addr, mem_wdata
    );
    modport slave(
        input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_en, mem_ren, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed bytes out of a 64-bit RAM word and extends them to 32 bits
module lsu_load_align
    import lsu_pkg::*;
(
    input logic [63:0] rdata,
    input logic [2:0] addr,
    input size_e size,
    input logic uns,
    output logic [31:0] data
);
    logic [31:0] w;
    logic [7:0] b;
    logic [15:0] h;
    // Lane select, then sign or zero extension by access size
    always_comb begin
        w = addr[2] ? rdata[63:32] : rdata[31:0];
        b = w[{addr[1:0], 3'b000} +: 8];
        h = addr[1] ? w[31:16] : w[15:0];
        data = size == SZ_B ? {{24{b[7] & ~uns}}, b} : size == SZ_H ? {{16{h[15] & ~uns}}, h} : w;
    end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: one-at-a-time RV32 load/store initiator for the 64-bit data RAM port
// Define LSU_BOUNDS_CHECK_EN to fault addresses beyond the RAM instead of aliasing them.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 131072
) (
    input logic clk,
    input logic rst_n,
    lsu_mem_port_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES / 8);
    state_e state, state_nx;
    logic we_q, uns_q, fault_q, accept, fault, oob;
    size_e size_q;
    logic [AW+2:0] addr_q;
    logic [31:0] wdata_q, rdata_q, ld_data;
    logic [7:0] mask;
    logic [63:0] wrep;
    assign accept = bus.req_valid && state == IDLE;
`ifdef LSU_BOUNDS_CHECK_EN
    assign oob = |bus.req_addr[31:AW+3];
`else
    assign oob = 1'b0;
`endif
    assign fault = bad_access(bus.req_size, bus.req_addr[1:0]) || oob;
    assign mask = (size_q == SZ_B ? MASK_B : size_q == SZ_H ? MASK_H : MASK_W) << addr_q[2:0];
    assign wrep = size_q == SZ_B ? {8{wdata_q[7:0]}} : size_q == SZ_H ? {4{wdata_q[15:0]}} : {2{wdata_q}};
    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // Next state and bus outputs; the RAM port is only driven during ISSUE
    always_comb begin
        state_nx = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_fault = 1'b0;
        bus.mem_en = 1'b0;
        bus.mem_ren = 1'b0;
        bus.mem_we = '0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = fault ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_ren = ~we_q;
                bus.mem_we = we_q ? mask : 8'h00;
                bus.mem_addr = addr_q[AW+2:3];
                bus.mem_wdata = we_q ? wrep : 64'h0;
                state_nx = we_q ? RESP : CAPTURE;
            end
            CAPTURE: state_nx = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_fault = fault_q;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Register the request at accept and the aligned load result in CAPTURE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            we_q <= 1'b0;
            size_q <= SZ_B;
            uns_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q <= bus.req_we;
            size_q <= size_e'(bus.req_size);
            uns_q <= bus.req_unsigned;
            addr_q <= bus.req_addr[AW+2:0];
            wdata_q <= bus.req_wdata;
            fault_q <= fault;
            rdata_q <= '0;
        end else if (state == CAPTURE) begin
            rdata_q <= ld_data;
        end
    lsu_load_align u_align (
        .rdata(bus.mem_rdata),
        .addr(addr_q[2:0]),
        .size(size_q),
        .uns(uns_q),
        .data(ld_data)
    );
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed bench with a byte-level memory model and a per-cycle output timeline
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int en_count = 0;
    logic [127:0] expq[$];
    logic [63:0] ram[0:16383];
    logic [7:0] mb[0:131071];
    logic [63:0] nw;
    logic [31:0] last_rdata;
    logic last_fault;
    logic [13:0] last_addr;
    logic [7:0] last_we;
    logic [63:0] last_wdata;

    lsu_mem_port_if bus();
    lsu_mem_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Simple synchronous RAM: read data appears the cycle after the access
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr];
            nw = ram[bus.mem_addr];
            for (int i = 0; i < 8; i++) if (bus.mem_we[i]) nw[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            ram[bus.mem_addr] <= nw;
        end
    end

    function automatic logic [127:0] pack(input logic rr, input logic rv, input logic [31:0] rd,
                                          input logic rf, input logic me, input logic mr,
                                          input logic [7:0] mw, input logic [13:0] ma, input logic [63:0] md);
        return {5'b0, rr, rv, rd, rf, me, mr, mw, ma, md};
    endfunction

    function automatic logic [127:0] actual();
        return pack(bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.mem_en,
                    bus.mem_ren, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every checked cycle: compare outputs against the next expected vector, else the idle vector
    always @(negedge clk) begin
        logic [127:0] e;
        if (chk_en) begin
            e = expq.size() > 0 ? expq.pop_front() : pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 14'h0, 64'h0);
            check("cycle", actual(), e);
            if (bus.rsp_valid) begin
                last_rdata = bus.rsp_rdata;
                last_fault = bus.rsp_fault;
            end
            if (bus.mem_en) begin
                en_count++;
                last_addr = bus.mem_addr;
                last_we = bus.mem_we;
                last_wdata = bus.mem_wdata;
            end
        end
    end

    task automatic run(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        int n;
        int lat;
        logic f;
        logic [31:0] a;
        logic [31:0] exp_rd;
        logic [7:0] m;
        logic [63:0] rep;
        n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        f = size == 2'd3 || (addr % n) != 0;
`ifdef LSU_BOUNDS_CHECK_EN
        f = f || addr >= 32'd131072;
`endif
        a = addr % 131072;
        exp_rd = 32'h0;
        if (!f && !we) begin
            for (int i = 0; i < n; i++) exp_rd |= 32'(mb[a + i]) << (8 * i);
            if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd |= ~((32'd1 << (8 * n)) - 32'd1);
        end
        m = 8'((1 << n) - 1) << (a % 8);
        for (int i = 0; i < 8; i++) rep[8*i +: 8] = wdata[8*(i % n) +: 8];
        if (!f && we) for (int i = 0; i < n; i++) mb[a + i] = wdata[8*i +: 8];
        lat = f ? 1 : we ? 2 : 3;
        @(negedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        if (hold > 0) bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (!f) begin
            expq.push_back(pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, !we, we ? m : 8'h0, a[16:3], we ? rep : 64'h0));
            if (!we) expq.push_back(pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 14'h0, 64'h0));
        end
        repeat (hold + 1) expq.push_back(pack(1'b0, 1'b1, exp_rd, f, 1'b0, 1'b0, 8'h0, 14'h0, 64'h0));
        repeat (lat + hold) @(negedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [63:0] w0, w1;
        w0 = 64'h01234567_89ABCDEF;
        w1 = 64'h8899AABB_CCDDEEFF;
        for (int i = 0; i < 16384; i++) ram[i] = 64'h0;
        for (int i = 0; i < 131072; i++) mb[i] = 8'h0;
        ram[0] = w0;
        ram[1] = w1;
        for (int i = 0; i < 8; i++) begin
            mb[i] = w0[8*i +: 8];
            mb[8 + i] = w1[8*i +: 8];
        end
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        #2;
        check("reset outputs", actual(), pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 14'h0, 64'h0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        run(1'b0, 2'd0, 1'b0, 32'h0F, 32'h0, 0);
        check("LB 0x0F rdata", last_rdata, 32'hFFFFFF88);
        check("LB 0x0F addr", last_addr, 14'd1);
        run(1'b0, 2'd0, 1'b1, 32'h0F, 32'h0, 0);
        check("LBU 0x0F rdata", last_rdata, 32'h00000088);
        run(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 0);
        check("LHU 0x0E rdata", last_rdata, 32'h00008899);
        run(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 0);
        check("LH 0x0E rdata", last_rdata, 32'hFFFF8899);
        run(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 0);
        check("LW 0x08 rdata", last_rdata, 32'hCCDDEEFF);

        run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        check("SW 0x10 addr", last_addr, 14'd2);
        check("SW 0x10 we", last_we, 8'h0F);
        check("SW 0x10 wdata", last_wdata, 64'hDEADBEEF_DEADBEEF);
        check("SW 0x10 rdata", last_rdata, 32'h0);
        run(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000005A, 0);
        check("SB 0x15 we", last_we, 8'h20);
        check("SB 0x15 wdata", last_wdata, 64'h5A5A5A5A_5A5A5A5A);
        run(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
        check("LW 0x14 rdata", last_rdata, 32'h00005A00);
        run(1'b1, 2'd1, 1'b0, 32'h1E, 32'h1234BEEF, 0);
        check("SH 0x1E we", last_we, 8'hC0);
        check("SH 0x1E wdata", last_wdata, 64'hBEEFBEEF_BEEFBEEF);
        run(1'b0, 2'd1, 1'b0, 32'h1E, 32'h0, 0);
        check("LH 0x1E rdata", last_rdata, 32'hFFFFBEEF);
        run(1'b0, 2'd0, 1'b1, 32'h1F, 32'h0, 0);
        check("LBU 0x1F rdata", last_rdata, 32'h000000BE);

        e0 = en_count;
        run(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0);
        check("LW 0x02 fault", last_fault, 1'b1);
        run(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF, 0);
        check("SH 0x03 fault", last_fault, 1'b1);
        run(1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 0);
        check("size3 fault", last_fault, 1'b1);
        check("faults no access", en_count, e0);

        run(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
        check("LW 0x20000 fault", last_fault, 1'b1);
`else
        check("LW 0x20000 alias", last_rdata, 32'h89ABCDEF);
        check("LW 0x20000 addr", last_addr, 14'd0);
`endif

        run(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 5);
        check("LW hold rdata", last_rdata, 32'hCCDDEEFF);
        run(1'b1, 2'd0, 1'b0, 32'h21, 32'h77, 3);
        run(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0);
        check("LB 0x21 rdata", last_rdata, 32'h00000077);

        chk_en = 1'b0;
        @(negedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h08;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #1;
        check("issue mem_en", bus.mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset mid-issue", actual(), pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 14'h0, 64'h0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        check("LW after reset", last_rdata, 32'hDEADBEEF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
